pd_block_led_ctrl: RTL and testbench

Controller that owns the 10-bit LED PIO slave of the inference subsystem and decides what it displays. It arbitrates between a CPU-programmed manual pattern and an automatic status display driven by the inference engine: a busy scanner and a class-result display. It is an Avalon-MM master on the LED PIO write port and an Avalon-MM slave for its own configuration. It issues a PIO write only when the displayed pattern must change.

---
 rtl/pd_led_pkg.sv | 10 +
 rtl/pd_led_tick_gen.sv | 17 +
 rtl/pd_block_led_ctrl.sv | 127 ++++++++++++
 tb/tb_pd_block_led_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pd_led_pkg.sv
// pd_led_pkg: register map, mode/state encodings and display constants for the LED controller
package pd_led_pkg;
  localparam logic [1:0] CTRL = 2'd0;
  localparam logic [1:0] MANUAL = 2'd1;
  localparam logic [1:0] SCAN_PERIOD = 2'd2;
  localparam logic [1:0] STATUS = 2'd3;
  typedef enum logic {MODE_MANUAL = 1'b0, MODE_AUTO = 1'b1} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, RESULT = 2'd2} auto_state_e;
  localparam logic [9:0] ERR_PATTERN = 10'h3FF;
endpackage

// File: rtl/pd_led_tick_gen.sv
// pd_led_tick_gen: scan prescaler, one-cycle tick every TICK_DIV clocks while not cleared
module pd_led_tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign tick = !clear && cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clear || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/pd_block_led_ctrl.sv
// pd_block_led_ctrl: arbitrates manual/auto LED patterns and writes the PIO only on change
module pd_block_led_ctrl
  import pd_led_pkg::*;
#(
  parameter int LED_W = 10,
  parameter int TICK_DIV = 500000,
  parameter int SCAN_RST = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  cfg_address,
  input  logic        cfg_chipselect,
  input  logic        cfg_write_n,
  input  logic [31:0] cfg_writedata,
  output logic [31:0] cfg_readdata,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic [3:0]  eng_class,
  output logic        pio_chipselect,
  output logic [1:0]  pio_address,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
);
  mode_e             mode_q;
  logic              enable_q;
  logic [LED_W-1:0]  manual_q;
  logic [7:0]        period_q;
  auto_state_e       state_q, state_d;
  logic [3:0]        cls_q;
  logic [LED_W-1:0]  scan_q;
  logic [7:0]        step_q;
  logic              busy_q;
  logic [LED_W-1:0]  shadow_q;
  logic              pio_cs_q;
  logic              cfg_we, auto_on, busy_rise, scan_run, tick, step_hit, wr, pending;
  logic [7:0]        eff_period;
  logic [LED_W-1:0]  result_pat, auto_pat, target;
  logic              unused_ok;
  assign unused_ok = ^cfg_writedata[31:LED_W];
  assign cfg_we = cfg_chipselect && !cfg_write_n;
  assign auto_on = enable_q && mode_q == MODE_AUTO;
  assign busy_rise = eng_busy && !busy_q;
  assign scan_run = auto_on && state_q == SCAN;
  assign eff_period = period_q == 8'd0 ? 8'd1 : period_q;
  // >= rather than == so a period shrunk below the current count steps on the next tick
  assign step_hit = step_q >= eff_period - 8'd1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mode_q <= MODE_MANUAL;
      enable_q <= 1'b0;
      manual_q <= '0;
      period_q <= 8'(SCAN_RST);
    end else if (cfg_we) begin
      if (cfg_address == CTRL) begin
        mode_q <= mode_e'(cfg_writedata[0]);
        enable_q <= cfg_writedata[1];
      end
      if (cfg_address == MANUAL) manual_q <= cfg_writedata[LED_W-1:0];
      if (cfg_address == SCAN_PERIOD) period_q <= cfg_writedata[7:0];
    end
  pd_led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset_n(reset_n),
    .clear(!scan_run),
    .tick(tick)
  );
  always_comb begin
    state_d = state_q;
    if (!auto_on) state_d = IDLE;
    else if (eng_done) state_d = RESULT;
    else if (state_q == SCAN) state_d = eng_busy ? SCAN : IDLE;
    else if (state_q == RESULT) state_d = busy_rise ? SCAN : RESULT;
    else state_d = eng_busy ? SCAN : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      cls_q <= '0;
      scan_q <= LED_W'(1);
      step_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= eng_busy;
      if (eng_done && state_d == RESULT) cls_q <= eng_class;
      if (!scan_run) begin
        scan_q <= LED_W'(1);
        step_q <= '0;
      end else if (tick) begin
        step_q <= step_hit ? 8'd0 : step_q + 8'd1;
        if (step_hit) scan_q <= {scan_q[LED_W-2:0], scan_q[LED_W-1]};
      end
    end
  always_comb begin
    result_pat = 32'(cls_q) < LED_W ? LED_W'(1) << cls_q : LED_W'(ERR_PATTERN);
    auto_pat = state_q == SCAN ? scan_q : state_q == RESULT ? result_pat : '0;
    target = !enable_q ? '0 : mode_q == MODE_AUTO ? auto_pat : manual_q;
  end
  assign pending = target != shadow_q;
  // a write is blocked during the cycle it is on the bus, coalescing fast target changes
  assign wr = !pio_cs_q && pending;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pio_cs_q <= 1'b0;
      shadow_q <= '0;
    end else begin
      pio_cs_q <= wr;
      if (wr) shadow_q <= target;
    end
  assign pio_chipselect = pio_cs_q;
  assign pio_write_n = !pio_cs_q;
  assign pio_address = 2'd0;
  assign pio_writedata = 32'(shadow_q);
  always_comb begin
    cfg_readdata = '0;
    case (cfg_address)
      CTRL: cfg_readdata[1:0] = {enable_q, mode_q};
      MANUAL: cfg_readdata[LED_W-1:0] = manual_q;
      SCAN_PERIOD: cfg_readdata[7:0] = period_q;
      default: begin
        cfg_readdata[LED_W-1:0] = shadow_q;
        cfg_readdata[16] = pending;
        cfg_readdata[18:17] = state_q;
      end
    endcase
  end
endmodule

// File: tb/tb_pd_block_led_ctrl.sv
// tb_pd_block_led_ctrl: directed vector bench for the LED controller
module tb_pd_block_led_ctrl;
  import pd_led_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] cfg_address = '0;
  logic cfg_chipselect = 1'b0;
  logic cfg_write_n = 1'b1;
  logic [31:0] cfg_writedata = '0;
  logic [31:0] cfg_readdata;
  logic eng_busy = 1'b0;
  logic eng_done = 1'b0;
  logic [3:0] eng_class = '0;
  logic pio_chipselect;
  logic [1:0] pio_address;
  logic pio_write_n;
  logic [31:0] pio_writedata;

  pd_block_led_ctrl #(.LED_W(10), .TICK_DIV(4), .SCAN_RST(10)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cfg_address(cfg_address),
    .cfg_chipselect(cfg_chipselect),
    .cfg_write_n(cfg_write_n),
    .cfg_writedata(cfg_writedata),
    .cfg_readdata(cfg_readdata),
    .eng_busy(eng_busy),
    .eng_done(eng_done),
    .eng_class(eng_class),
    .pio_chipselect(pio_chipselect),
    .pio_address(pio_address),
    .pio_write_n(pio_write_n),
    .pio_writedata(pio_writedata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [9:0] wq[$];
  int tq[$];
  logic [31:0] r;

  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (reset_n && pio_chipselect && !pio_write_n) begin
      wq.push_back(pio_writedata[9:0]);
      tq.push_back(cyc);
    end

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } reg_vec_t;
  typedef struct {
    logic [3:0] cls;
    logic [9:0] pat;
  } cls_vec_t;
  reg_vec_t rv[6];
  cls_vec_t cv[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    cfg_address = a;
    cfg_writedata = d;
    cfg_chipselect = 1'b1;
    cfg_write_n = 1'b0;
    step(1);
    cfg_chipselect = 1'b0;
    cfg_write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cfg_address = a;
    #1;
    d = cfg_readdata;
  endtask

  task automatic done_pulse(input logic [3:0] c, input logic b);
    eng_done = 1'b1;
    eng_class = c;
    eng_busy = b;
    step(1);
    eng_done = 1'b0;
    eng_class = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rv[0] = '{MANUAL, 32'hFFFF_F155, 32'h0000_0155};
    rv[1] = '{SCAN_PERIOD, 32'h0000_01FF, 32'h0000_00FF};
    rv[2] = '{SCAN_PERIOD, 32'h0000_0000, 32'h0000_0000};
    rv[3] = '{CTRL, 32'hFFFF_FFFD, 32'h0000_0001};
    rv[4] = '{STATUS, 32'hFFFF_FFFF, 32'h0000_0000};
    rv[5] = '{CTRL, 32'hFFFF_FFFC, 32'h0000_0000};
    cv[0] = '{4'd12, 10'h3FF};
    cv[1] = '{4'd0, 10'h001};
    cv[2] = '{4'd9, 10'h200};
    cv[3] = '{4'd10, 10'h3FF};
    cv[4] = '{4'd15, 10'h3FF};
    cv[5] = '{4'd5, 10'h020};

    step(3);
    chk("rst_cs", 32'(pio_chipselect), 0);
    chk("rst_wn", 32'(pio_write_n), 1);
    reset_n = 1'b1;
    step(1);
    chk("rst_addr", 32'(pio_address), 0);
    chk("rst_data", pio_writedata, 0);
    rd(CTRL, r);        chk("rst_ctrl", r, 0);
    rd(MANUAL, r);      chk("rst_manual", r, 0);
    rd(SCAN_PERIOD, r); chk("rst_period", r, 10);
    rd(STATUS, r);      chk("rst_status", r, 0);

    foreach (rv[i]) begin
      cfg_wr(rv[i].addr, rv[i].wdata);
      rd(rv[i].addr, r);
      chk($sformatf("reg_vec%0d", i), r, rv[i].rexp);
    end
    step(2);
    chk("disabled_no_write", 32'(wq.size()), 0);

    cfg_wr(CTRL, 32'h2);
    chk("man_cs_pre", 32'(pio_chipselect), 0);
    rd(STATUS, r);      chk("man_pending", r, 32'h0001_0000);
    step(1);
    chk("man_cs", 32'(pio_chipselect), 1);
    chk("man_wn", 32'(pio_write_n), 0);
    chk("man_data", pio_writedata, 32'h155);
    step(1);
    chk("man_cs_post", 32'(pio_chipselect), 0);
    chk("man_wn_post", 32'(pio_write_n), 1);
    step(3);
    chk("man_write_count", 32'(wq.size()), 1);
    rd(STATUS, r);      chk("man_status", r, 32'h155);

    wq.delete();
    cfg_wr(MANUAL, 32'h1);
    cfg_wr(MANUAL, 32'h2);
    cfg_wr(MANUAL, 32'h3);
    step(5);
    chk("coalesce_count_le2", 32'(wq.size() inside {1, 2}), 1);
    chk("coalesce_last", wq.size() > 0 ? 32'(wq[wq.size()-1]) : 32'hDEAD, 3);
    chk("coalesce_data", pio_writedata, 3);

    cfg_wr(SCAN_PERIOD, 32'h1);
    cfg_wr(CTRL, 32'h3);
    step(4);
    wq.delete();
    tq.delete();
    eng_busy = 1'b1;
    for (int i = 0; i < 200 && wq.size() < 11; i++) step(1);
    chk("scan_count", 32'(wq.size() >= 11), 1);
    if (wq.size() >= 11)
      for (int i = 0; i < 11; i++) begin
        chk($sformatf("scan_pat%0d", i), 32'(wq[i]), 32'(10'd1 << (i % 10)));
        if (i > 0) chk($sformatf("scan_gap%0d", i), 32'(tq[i] - tq[i-1]), 4);
      end

    done_pulse(4'd3, 1'b0);
    step(3);
    chk("res_data3", pio_writedata, 32'h008);
    rd(STATUS, r);      chk("res_state", 32'(r[18:17]), 2);
    step(20);
    chk("res_hold", pio_writedata, 32'h008);
    foreach (cv[i]) begin
      done_pulse(cv[i].cls, 1'b0);
      step(3);
      chk($sformatf("cls_vec%0d", i), pio_writedata, 32'(cv[i].pat));
      rd(STATUS, r);
      chk($sformatf("cls_shadow%0d", i), 32'(r[9:0]), 32'(cv[i].pat));
    end

    cfg_wr(CTRL, 32'h1);
    cfg_wr(CTRL, 32'h3);
    rd(STATUS, r);      chk("both_pre_idle", 32'(r[18:17]), 0);
    done_pulse(4'd7, 1'b1);
    eng_busy = 1'b0;
    step(3);
    chk("both_result", pio_writedata, 32'h080);
    rd(STATUS, r);      chk("both_state", 32'(r[18:17]), 2);
    wq.delete();
    eng_busy = 1'b1;
    step(3);
    rd(STATUS, r);      chk("rise_scan", 32'(r[18:17]), 1);
    chk("rise_first", wq.size() > 0 ? 32'(wq[0]) : 32'hDEAD, 1);

    step(6);
    wq.delete();
    cfg_wr(CTRL, 32'h1);
    step(3);
    chk("dis_data", pio_writedata, 0);
    chk("dis_last", wq.size() > 0 ? 32'(wq[wq.size()-1]) : 32'hDEAD, 0);
    rd(STATUS, r);      chk("dis_status", r, 0);
    wq.delete();
    cfg_wr(CTRL, 32'h3);
    step(4);
    chk("reen_first", wq.size() > 0 ? 32'(wq[0]) : 32'hDEAD, 1);

    eng_busy = 1'b0;
    cfg_wr(CTRL, 32'h2);
    step(4);
    cfg_wr(MANUAL, 32'h2AA);
    step(1);
    chk("mid_cs", 32'(pio_chipselect), 1);
    reset_n = 1'b0;
    #1;
    chk("async_cs", 32'(pio_chipselect), 0);
    chk("async_wn", 32'(pio_write_n), 1);
    chk("async_data", pio_writedata, 0);
    rd(CTRL, r);        chk("async_ctrl", r, 0);
    step(2);
    reset_n = 1'b1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
